// File: rtl/llr_frame_loader.sv
// Frame loader for the LDPC bit-node memory: handshaked line intake, LLR width
// conversion, line/frame counting and framing check. Optional: LLR_SAT_EN.
module llr_frame_loader #(
    parameter int W      = 6,
    parameter int WIN    = 8,
    parameter int Nb     = 16,
    parameter int LANES  = 32,
    parameter int LINES  = 17,
    parameter int LINEW  = 5,
    parameter int FRAMEW = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*Nb*WIN-1:0]     s_data,
    input  logic                        s_last,
    output logic                        loaden,
    output logic [LANES*Nb*W-1:0]       load_data,
    output logic [LINEW-1:0]            line_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [FRAMEW-1:0]           frame_cnt
);
    localparam int LW = LANES * Nb;
    localparam logic [LINEW-1:0] LAST = LINEW'(LINES - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state_q, state_d;
    logic [LINEW-1:0]    cnt_q, cnt_d;
    logic                loaden_q, loaden_d;
    logic [LW*W-1:0]     data_q, data_d;
    logic [LINEW-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [FRAMEW-1:0]   frame_q, frame_d;
    logic [LW*W-1:0]     conv;
    logic                is_last;

`ifdef LLR_SAT_EN
    localparam int PMAX = 2 ** (W - 1) - 1;
    localparam logic signed [WIN-1:0] POS = PMAX[WIN-1:0];
    localparam logic signed [WIN-1:0] NEG = -POS;
    logic signed [WIN-1:0] lv;

    // Symmetric clamp keeps -2**(W-1) out so negation stays in range downstream
    always_comb begin
        conv = '0;
        lv   = '0;
        for (int k = 0; k < LW; k++) begin
            lv = s_data[k*WIN +: WIN];
            if (lv > POS)
                conv[k*W +: W] = POS[W-1:0];
            else if (lv < NEG)
                conv[k*W +: W] = NEG[W-1:0];
            else
                conv[k*W +: W] = lv[W-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^s_data;

    always_comb begin
        conv = '0;
        for (int k = 0; k < LW; k++)
            conv[k*W +: W] = s_data[k*WIN +: W];
    end
`endif

    assign is_last = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            loaden_q <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaden_q <= loaden_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaden_d = 1'b0;
        data_d   = data_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = err_q;
        frame_d  = frame_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    loaden_d = 1'b1;
                    data_d   = conv;
                    idx_d    = cnt_q;
                    cnt_d    = cnt_q + 1'b1;
                    // Length is fixed; s_last only feeds the framing check
                    if (s_last != is_last)
                        err_d = 1'b1;
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q == LOAD);
    assign loaden    = loaden_q;
    assign load_data = data_q;
    assign line_idx  = idx_q;
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_q;
endmodule

// File: tb/tb_llr_frame_loader.sv
// Self-checking bench for llr_frame_loader against a spec-level reference
// model; a second instance with FRAMEW=2 covers frame counter wrap.
module tb_llr_frame_loader;
    localparam int W     = 6;
    localparam int WIN   = 8;
    localparam int NB    = 16;
    localparam int LANES = 32;
    localparam int LINES = 17;
    localparam int LINEW = 5;
    localparam int LW    = LANES * NB;

    logic              clk = 1'b0;
    logic              rst, start, s_valid, s_last;
    logic [LW*WIN-1:0] s_data;
    logic              s_ready, loaden, busy, done, err;
    logic [LW*W-1:0]   load_data;
    logic [LINEW-1:0]  line_idx;
    logic [7:0]        frame_cnt;
    logic              s_ready2, loaden2, busy2, done2, err2;
    logic [LW*W-1:0]   load_data2;
    logic [LINEW-1:0]  line_idx2;
    logic [1:0]        frame_cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              e_busy;
    int              e_cnt;
    bit              e_loaden, e_done, e_err;
    logic [LW*W-1:0] e_ld;
    int              e_idx, e_fc, e_fc2;

    always #5 clk = ~clk;

    llr_frame_loader #(.W(W), .WIN(WIN), .Nb(NB), .LANES(LANES),
        .LINES(LINES), .LINEW(LINEW), .FRAMEW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .loaden(loaden), .load_data(load_data), .line_idx(line_idx),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt));

    llr_frame_loader #(.W(W), .WIN(WIN), .Nb(NB), .LANES(LANES),
        .LINES(LINES), .LINEW(LINEW), .FRAMEW(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid),
        .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
        .loaden(loaden2), .load_data(load_data2), .line_idx(line_idx2),
        .busy(busy2), .done(done2), .err(err2), .frame_cnt(frame_cnt2));

    function automatic logic [W-1:0] cv(input logic [WIN-1:0] x);
        int v;
        int m;
        v = int'($signed(x));
        m = 2 ** (W - 1) - 1;
`ifdef LLR_SAT_EN
        if (v > m) v = m;
        if (v < -m) v = -m;
`endif
        return v[W-1:0];
    endfunction

    function automatic logic [LW*W-1:0] conv_line(input logic [LW*WIN-1:0] d);
        logic [LW*W-1:0] r;
        r = '0;
        for (int k = 0; k < LW; k++)
            r[k*W +: W] = cv(d[k*WIN +: WIN]);
        return r;
    endfunction

    function automatic logic [LW*WIN-1:0] rline();
        logic [LW*WIN-1:0] r;
        r = '0;
        for (int k = 0; k < LW; k++)
            r[k*WIN +: WIN] = WIN'($urandom);
        return r;
    endfunction

    function automatic logic [LW*WIN-1:0] pline(input int i);
        logic [LW*WIN-1:0] r;
        r = '0;
        for (int k = 0; k < LW; k++)
            r[k*WIN +: WIN] = WIN'((i + k) % 16);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [LW*W-1:0] obs,
                            input logic [LW*W-1:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int k = LW - 1; k >= 0; k--)
                if (obs[k*W +: W] !== exp[k*W +: W]) bad = k;
            $error("FAIL %s: lane %0d observed %0h expected %0h", tag, bad,
                   obs[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    task automatic check_all();
        chk("s_ready", 32'(s_ready), 32'(e_busy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("loaden", 32'(loaden), 32'(e_loaden));
        chk_data("load_data", load_data, e_ld);
        chk("line_idx", 32'(line_idx), e_idx);
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("frame_cnt", 32'(frame_cnt), e_fc);
        chk("frame_cnt_w2", 32'(frame_cnt2), e_fc2);
        chk("loaden_w2", 32'(loaden2), 32'(e_loaden));
        chk("done_w2", 32'(done2), 32'(e_done));
    endtask

    // Drive one cycle of line inputs, advance the model over the edge, check
    task automatic cycle(input logic v, input logic [LW*WIN-1:0] d,
                         input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        if (rst) begin
            e_busy = 0; e_cnt = 0; e_loaden = 0; e_done = 0; e_err = 0;
            e_ld = '0; e_idx = 0; e_fc = 0; e_fc2 = 0;
        end else if (!e_busy) begin
            e_loaden = 0;
            e_done   = 0;
            if (start) begin
                e_busy = 1; e_cnt = 0; e_err = 0;
            end
        end else if (v) begin
            e_loaden = 1;
            e_ld     = conv_line(d);
            e_idx    = e_cnt;
            if (l != (e_cnt == LINES - 1)) e_err = 1;
            e_done = (e_cnt == LINES - 1);
            if (e_done) begin
                e_busy = 0;
                e_fc   = (e_fc + 1) % 256;
                e_fc2  = (e_fc2 + 1) % 4;
            end
            e_cnt++;
        end else begin
            e_loaden = 0;
            e_done   = 0;
        end
        s_valid = 0;
        s_last  = 0;
        check_all();
    endtask

    task automatic lines(input int from, input int to, input int la,
                         input int lb);
        for (int i = from; i <= to; i++)
            cycle(1'b1, rline(), (i == la) || (i == lb));
    endtask

    task automatic do_start();
        start = 1;
        cycle(1'b0, '0, 1'b0);
        start = 0;
    endtask

    logic [LW*WIN-1:0] sat;
    logic [4*W-1:0]    sat_exp;

    initial begin
        rst = 1; start = 0; s_valid = 0; s_last = 0; s_data = '0;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        rst = 0;
        chk("rst s_ready", 32'(s_ready), 0);
        chk("rst loaden", 32'(loaden), 0);
        chk_data("rst load_data", load_data, '0);
        chk("rst line_idx", 32'(line_idx), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst frame_cnt", 32'(frame_cnt), 0);

        // s_valid in IDLE is not consumed
        cycle(1'b1, rline(), 1'b0);
        cycle(1'b1, rline(), 1'b1);

        // Frame 1: pattern data, correct s_last
        do_start();
        chk("start s_ready", 32'(s_ready), 1);
        for (int i = 0; i < LINES; i++) begin
            cycle(1'b1, pline(i), i == LINES - 1);
            chk("pattern idx", 32'(line_idx), i);
        end
        chk("frame1 done", 32'(done), 1);
        chk("frame1 cnt", 32'(frame_cnt), 1);
        chk("frame1 err", 32'(err), 0);

        // Frame 2: conversion corners on line 0, 3-cycle gap after line 5
        do_start();
        sat = rline();
        sat[0*WIN +: WIN] = 8'h7F;
        sat[1*WIN +: WIN] = 8'h80;
        sat[2*WIN +: WIN] = 8'h05;
        sat[3*WIN +: WIN] = 8'hF0;
`ifdef LLR_SAT_EN
        sat_exp = {6'h30, 6'h05, 6'h21, 6'h1F};
`else
        sat_exp = {6'h30, 6'h05, 6'h00, 6'h3F};
`endif
        cycle(1'b1, sat, 1'b0);
        chk("conv lanes0-3", 32'(load_data[4*W-1:0]), 32'(sat_exp));
        lines(1, 5, -1, -1);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, rline(), 1'b0);
            chk("gap loaden", 32'(loaden), 0);
            chk("gap line_idx", 32'(line_idx), 5);
        end
        lines(6, LINES - 1, LINES - 1, -1);
        chk("frame2 done", 32'(done), 1);

        // Frame 3: early s_last on line 10
        do_start();
        lines(0, 10, 10, LINES - 1);
        chk("early last err", 32'(err), 1);
        lines(11, LINES - 1, 10, LINES - 1);
        chk("early last done", 32'(done), 1);
        chk("early last err held", 32'(err), 1);
        do_start();
        chk("start clears err", 32'(err), 0);

        // Reset mid-frame after line 8
        lines(0, 8, LINES - 1, -1);
        rst = 1;
        cycle(1'b1, rline(), 1'b0);
        rst = 0;
        chk("abort s_ready", 32'(s_ready), 0);
        chk("abort done", 32'(done), 0);
        chk("abort loaden", 32'(loaden), 0);
        chk("abort frame_cnt", 32'(frame_cnt), 0);
        cycle(1'b1, rline(), 1'b0);
        do_start();
        lines(0, LINES - 1, LINES - 1, -1);
        chk("post-abort frame_cnt", 32'(frame_cnt), 1);

        // start held high: back-to-back frames, then FRAMEW=2 wrap
        rst = 1;
        cycle(1'b0, '0, 1'b0);
        rst = 0;
        start = 1;
        cycle(1'b0, '0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            lines(0, LINES - 1, LINES - 1, -1);
            chk("b2b done", 32'(done), 1);
            cycle(1'b1, rline(), 1'b0);
            chk("b2b restart busy", 32'(busy), 1);
            if (f == 1) chk("b2b frame_cnt", 32'(frame_cnt), 2);
        end
        start = 0;
        chk("wrap frame_cnt_w2", 32'(frame_cnt2), 1);
        chk("wrap frame_cnt", 32'(frame_cnt), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
